// File: rtl/fidus_axi4lite_slv_regfile.sv
// rtl/fidus_axi4lite_slv_regfile.sv - AXI4-Lite slave register file with programmable B/R response latency
// Independent write and read channel FSMs; one outstanding transaction per channel.
module fidus_axi4lite_slv_regfile #(
    parameter int AWIDTH     = 8,
    parameter int DWIDTH     = 16,
    parameter int NUM_REGS   = 16,
    parameter int WR_LATENCY = 0,
    parameter int RD_LATENCY = 0,
    parameter logic [DWIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic [AWIDTH-1:0]          awaddr,
    input  logic                       awvalid,
    output logic                       awready,
    input  logic [DWIDTH-1:0]          wdata,
    input  logic [DWIDTH/8-1:0]        wstrb,
    input  logic                       wvalid,
    output logic                       wready,
    output logic [1:0]                 bresp,
    output logic                       bvalid,
    input  logic                       bready,
    input  logic [AWIDTH-1:0]          araddr,
    input  logic                       arvalid,
    output logic                       arready,
    output logic [DWIDTH-1:0]          rdata,
    output logic [1:0]                 rresp,
    output logic                       rvalid,
    input  logic                       rready,
    output logic [NUM_REGS*DWIDTH-1:0] regs_o
);
    localparam int NB    = DWIDTH / 8;
    localparam int SHIFT = $clog2(NB);
    localparam logic [AWIDTH:0] NREGS_W = (AWIDTH+1)'(NUM_REGS);
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_t;

    logic [DWIDTH-1:0] regs_q [NUM_REGS];

    wstate_t           wstate_q, wstate_d;
    logic              awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              aw_got_q, aw_got_d, w_got_q, w_got_d;
    logic [AWIDTH-1:0] awaddr_q, awaddr_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic [NB-1:0]     wstrb_q, wstrb_d;
    logic [7:0]        wcnt_q, wcnt_d;
    logic              aw_hs, w_hs, commit, w_inrange;
    logic [AWIDTH-1:0] w_addr, w_idx;
    logic [DWIDTH-1:0] w_data;
    logic [NB-1:0]     w_strb;

    rstate_t           rstate_q, rstate_d;
    logic              arready_q, arready_d, rvalid_q, rvalid_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d, rd_val;
    logic [7:0]        rcnt_q, rcnt_d;
    logic              ar_hs, ar_inrange;
    logic [AWIDTH-1:0] ar_idx;

    // A channel captured in an earlier cycle is taken from its holding register.
    always_comb begin
        aw_hs     = (wstate_q == W_IDLE) && awvalid && awready_q;
        w_hs      = (wstate_q == W_IDLE) && wvalid && wready_q;
        w_addr    = aw_got_q ? awaddr_q : awaddr;
        w_data    = w_got_q ? wdata_q : wdata;
        w_strb    = w_got_q ? wstrb_q : wstrb;
        w_idx     = w_addr >> SHIFT;
        w_inrange = {1'b0, w_idx} < NREGS_W;
        commit    = (wstate_q == W_IDLE) && (aw_got_q || aw_hs) && (w_got_q || w_hs);

        wstate_d  = wstate_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        aw_got_d  = aw_got_q;
        w_got_d   = w_got_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        wcnt_d    = wcnt_q;
        case (wstate_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_got_d  = 1'b1;
                    awaddr_d  = awaddr;
                    awready_d = 1'b0;
                end
                if (w_hs) begin
                    w_got_d  = 1'b1;
                    wdata_d  = wdata;
                    wstrb_d  = wstrb;
                    wready_d = 1'b0;
                end
                if (commit) begin
                    aw_got_d  = 1'b0;
                    w_got_d   = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    bresp_d   = w_inrange ? OKAY : SLVERR;
                    wcnt_d    = 8'd0;
                    if (WR_LATENCY == 0) begin
                        wstate_d = W_RESP;
                        bvalid_d = 1'b1;
                    end else begin
                        wstate_d = W_WAIT;
                    end
                end
            end
            W_WAIT: begin
                if (wcnt_q == 8'(WR_LATENCY - 1)) begin
                    wstate_d = W_RESP;
                    bvalid_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            W_RESP: begin
                if (bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    wstate_d  = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wcnt_q    <= 8'd0;
        end else begin
            wstate_q  <= wstate_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            wcnt_q    <= wcnt_d;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VALUE;
        end else if (commit && w_inrange) begin
            for (int i = 0; i < NUM_REGS; i++)
                if (w_idx == AWIDTH'(i))
                    for (int k = 0; k < NB; k++)
                        if (w_strb[k]) regs_q[i][k*8 +: 8] <= w_data[k*8 +: 8];
        end
    end

    // Read samples the pre-commit array, so a same-edge write returns the old value.
    always_comb begin
        ar_hs      = (rstate_q == R_IDLE) && arvalid && arready_q;
        ar_idx     = araddr >> SHIFT;
        ar_inrange = {1'b0, ar_idx} < NREGS_W;
        rd_val     = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (ar_idx == AWIDTH'(i)) rd_val = regs_q[i];

        rstate_d  = rstate_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        rcnt_d    = rcnt_q;
        case (rstate_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rdata_d   = rd_val;
                    rresp_d   = ar_inrange ? OKAY : SLVERR;
                    arready_d = 1'b0;
                    rcnt_d    = 8'd0;
                    if (RD_LATENCY == 0) begin
                        rstate_d = R_RESP;
                        rvalid_d = 1'b1;
                    end else begin
                        rstate_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (rcnt_q == 8'(RD_LATENCY - 1)) begin
                    rstate_d = R_RESP;
                    rvalid_d = 1'b1;
                end else begin
                    rcnt_d = rcnt_q + 8'd1;
                end
            end
            R_RESP: begin
                if (rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    rstate_d  = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rresp_q   <= OKAY;
            rdata_q   <= '0;
            rcnt_q    <= 8'd0;
        end else begin
            rstate_q  <= rstate_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            rcnt_q    <= rcnt_d;
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rresp   = rresp_q;
    assign rdata   = rdata_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_o[g*DWIDTH +: DWIDTH] = regs_q[g];
    end
endmodule
